// File: rtl/chronos_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chronos_fetch_pkg;

    localparam int unsigned INST_W        = 32;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch: the word together with the PC it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: DEPTH-entry FIFO of {pc,data} entries with flush.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
// Ports: clk, rst (async active-low), push/push_dat, pop, flush,
//        head_dat (zero when empty), count, full, empty.
module fetch_buf
    import chronos_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t      mem_q [DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is forced to zero when empty so stale entries never leak to decode.
    assign head_dat = empty ? '0 : mem_q[rd_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= push_dat;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: holds the PC, issues one word request at a time, buffers
//   returned words with their PC and hands them to decode; handles redirects.
// Latency: same-cycle memory -> word at decode one cycle after the response edge,
//   sustaining one instruction per cycle; backpressure: fetch_req drops while the
//   buffer is full, decode stalls via inst_ready.
// Ports: clk, rst (async active-low); memory side fetch_addr/fetch_req/request_data/
//   fetch_data_valid; redirect_valid/redirect_pc; decode side inst_valid/inst_data/
//   inst_pc/inst_ready; fetch_timeout (sticky watchdog, only with INST_FETCH_TIMEOUT_EN).
module inst_fetch_ctrl
    import chronos_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [INST_W-1:0] fetch_addr,
    output logic              fetch_req,
    input  logic [INST_W-1:0] request_data,
    input  logic              fetch_data_valid,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [INST_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_timeout
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    if (BUF_DEPTH < 2 || BUF_DEPTH > 8 || (RESET_PC & 32'h3) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("inst_fetch_ctrl: illegal parameter value");
    end

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] tgt_q, tgt_d;     // redirect target held while draining
    logic [INST_W-1:0] redir_pc;

    logic              buf_push, buf_pop;
    logic              buf_full, buf_empty;
    logic [CW-1:0]     buf_cnt;
    fetch_entry_t      buf_in, buf_head;

    assign redir_pc   = redirect_pc & PC_ALIGN_MASK;
    assign fetch_addr = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        fetch_req = 1'b0;
        buf_push  = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redir_pc;
            end
            REQ: begin
                fetch_req = (buf_cnt < CW'(BUF_DEPTH));
                if (redirect_valid) begin
                    // A request still in flight must be answered before the new
                    // address can go out, so park the target and drain.
                    if (fetch_req && !fetch_data_valid) begin
                        tgt_d   = redir_pc;
                        state_d = DRAIN;
                    end else begin
                        pc_d = redir_pc;
                    end
                end else if (fetch_req && fetch_data_valid) begin
                    buf_push = 1'b1;
                    pc_d     = pc_q + PC_INC;
                end
            end
            DRAIN: begin
                fetch_req = 1'b1;
                if (redirect_valid) tgt_d = redir_pc;
                if (fetch_data_valid) begin
                    // The stale word is dropped; a redirect arriving on the same
                    // edge supersedes the parked target.
                    pc_d    = redirect_valid ? redir_pc : tgt_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // A pop in the redirect cycle belongs to the flushed stream and is void.
    assign buf_pop     = inst_valid && inst_ready && !redirect_valid;
    assign buf_in.pc   = pc_q;
    assign buf_in.data = request_data;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (buf_push && !buf_full),
        .push_dat (buf_in),
        .pop      (buf_pop),
        .flush    (redirect_valid),
        .head_dat (buf_head),
        .count    (buf_cnt),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    assign inst_valid = !buf_empty;
    assign inst_pc    = buf_head.pc;
    assign inst_data  = buf_head.data;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d;

    // Counts consecutive unanswered request cycles; saturates at the limit.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (fetch_req && fetch_data_valid) begin
            wd_cnt_d = '0;
        end else if (fetch_req && (wd_cnt_q != TMAX)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (wd_cnt_d == TMAX) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign fetch_timeout = timeout_q;
`else
    assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus randomized traffic against a
// stream-level model (delivered PCs must follow the sequential/redirect order and
// carry the memory's word for that PC).
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic [31:0] request_data = '0;
    logic        fetch_data_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_timeout;

    inst_fetch_ctrl #(
        .RESET_PC       (RESET_PC),
        .BUF_DEPTH      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_addr       (fetch_addr),
        .fetch_req        (fetch_req),
        .request_data     (request_data),
        .fetch_data_valid (fetch_data_valid),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .inst_ready       (inst_ready),
        .fetch_timeout    (fetch_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // memory model state
    int  mem_lat     = 0;
    bit  mem_rand    = 1'b0;
    int  mem_cur_lat = 0;
    int  mem_seen    = 0;

    // stream model state
    logic [31:0] exp_pc     = RESET_PC;
    bit          exp_empty  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_addr  = '0;
    int          n_deliv    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: memory responds to what is visible, the model checks the
    // pre-edge view, then the edge happens. Called at posedge+1.
    task automatic tick();
        if (fetch_req) begin
            if (mem_seen == 0) mem_cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            if (mem_seen >= mem_cur_lat) begin
                fetch_data_valid = 1'b1;
                request_data     = mem_word(fetch_addr);
                mem_seen         = 0;
            end else begin
                fetch_data_valid = 1'b0;
                request_data     = $urandom;
                mem_seen++;
            end
        end else begin
            fetch_data_valid = 1'b0;
            request_data     = $urandom;
        end
        #1;
        if (exp_empty) begin
            check_val("flush_empty", 32'(inst_valid), 32'd0);
            exp_empty = 1'b0;
        end
        if (stall_prev) begin
            check_val("addr_hold", fetch_addr, prev_addr);
            check_val("req_hold", 32'(fetch_req), 32'd1);
        end
        if (!inst_valid) begin
            check_val("idle_data", inst_data, 32'd0);
            check_val("idle_pc", inst_pc, 32'd0);
        end
        if (redirect_valid) begin
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            exp_empty = 1'b1;
        end else if (inst_valid && inst_ready) begin
            check_val("deliv_pc", inst_pc, exp_pc);
            check_val("deliv_dat", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        stall_prev = fetch_req && !fetch_data_valid;
        prev_addr  = fetch_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst              = 1'b0;
        redirect_valid   = 1'b0;
        fetch_data_valid = 1'b0;
        #1;
        check_val("rst_req", 32'(fetch_req), 32'd0);
        check_val("rst_addr", fetch_addr, RESET_PC);
        check_val("rst_ivld", 32'(inst_valid), 32'd0);
        check_val("rst_idat", inst_data, 32'd0);
        check_val("rst_ipc", inst_pc, 32'd0);
        check_val("rst_to", 32'(fetch_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        exp_pc     = RESET_PC;
        exp_empty  = 1'b0;
        stall_prev = 1'b0;
        mem_seen   = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int k;

        // ---- streaming with same-cycle memory ----
        mem_lat = 0; mem_rand = 1'b0; inst_ready = 1'b1;
        #1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            check_val("t1_addr", fetch_addr, 32'(4 * i));
            if (i > 0) begin
                check_val("t1_ivld", 32'(inst_valid), 32'd1);
                check_val("t1_ipc", inst_pc, 32'(4 * (i - 1)));
            end
            tick();
        end
        repeat (6) tick();

        // ---- decode stall fills the buffer ----
        inst_ready = 1'b0;
        apply_reset();
        repeat (5) tick();
        check_val("t2_req_full", 32'(fetch_req), 32'd0);
        check_val("t2_addr", fetch_addr, 32'h8);
        check_val("t2_ivld", 32'(inst_valid), 32'd1);
        check_val("t2_ipc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (10) tick();

        // ---- redirect while a slow request is outstanding ----
        mem_lat = 3;
        apply_reset();
        for (k = 0; k < 20 && fetch_addr != 32'h4; k++) tick();
        check_val("t3_reach4", fetch_addr, 32'h4);
        tick();
        do_redirect(32'h100);
        check_val("t3_drain_addr", fetch_addr, 32'h4);
        check_val("t3_drain_req", 32'(fetch_req), 32'd1);
        check_val("t3_drain_ivld", 32'(inst_valid), 32'd0);
        k = 0;
        while (fetch_addr == 32'h4 && k < 20) begin
            tick();
            k++;
        end
        check_val("t3_drain_cycles", 32'(k), 32'd2);
        check_val("t3_new_addr", fetch_addr, 32'h100);
        for (k = 0; k < 20 && !inst_valid; k++) tick();
        check_val("t3_first_pc", inst_pc, 32'h100);

        // ---- redirect coincident with a response and a pop ----
        mem_lat = 0;
        repeat (4) tick();
        check_val("t4_pre_req", 32'(fetch_req), 32'd1);
        check_val("t4_pre_ivld", 32'(inst_valid), 32'd1);
        do_redirect(32'h203);
        check_val("t4_ivld", 32'(inst_valid), 32'd0);
        check_val("t4_addr", fetch_addr, 32'h200);
        tick();
        check_val("t4_first_pc", inst_pc, 32'h200);
        repeat (4) tick();

        // ---- PC wrap ----
        do_redirect(32'hFFFF_FFFC);
        check_val("t5_addr_top", fetch_addr, 32'hFFFF_FFFC);
        tick();
        check_val("t5_addr_wrap", fetch_addr, 32'h0);
        check_val("t5_ipc_top", inst_pc, 32'hFFFF_FFFC);
        tick();
        check_val("t5_ipc_wrap", inst_pc, 32'h0);

        // ---- asynchronous reset in the middle of a drain ----
        do_redirect(32'h40);
        repeat (2) tick();
        mem_lat = 1000;
        repeat (2) tick();
        do_redirect(32'h80);
        check_val("t6_pre_req", 32'(fetch_req), 32'd1);
        check_val("t6_pre_addr_nz", 32'(fetch_addr != 32'h0), 32'd1);
        apply_reset();

        // ---- watchdog with a memory that never answers ----
        repeat (15) tick();
        check_val("t7_to_early", 32'(fetch_timeout), 32'd0);
        tick();
        check_val("t7_to_at16", 32'(fetch_timeout), 32'(TO_EXP));
        repeat (5) tick();
        check_val("t7_to_sticky", 32'(fetch_timeout), 32'(TO_EXP));
        check_val("t7_still_req", 32'(fetch_req), 32'd1);

        // ---- randomized traffic ----
        mem_rand = 1'b1;
        apply_reset();
        n_deliv = 0;
        for (int c = 0; c < 800; c++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom & 32'h0000_03FF;
            tick();
            redirect_valid = 1'b0;
        end
        check_val("rand_liveness", 32'(n_deliv > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

endmodule
